// File: rtl/ram_frame_dumper_pkg.sv
// Shared types and constants for the frame dumper: FSM state, frame geometry and,
// when DUMP_BMP_HEADER_EN is defined, the 54-byte BMP header table.
package frame_dump_pkg;

   localparam int IMG_W         = 256;
   localparam int IMG_H         = 256;
   localparam int HDR_LEN       = 54;
   localparam int BYTES_PER_PIX = 3;
   localparam int PIX_BITS      = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      PIX  = 2'd2,
      FIN  = 2'd3
   } state_t;

`ifdef DUMP_BMP_HEADER_EN
   // BITMAPFILEHEADER + BITMAPINFOHEADER for a 256x256 24bpp image, file size 196662.
   localparam logic [7:0] HDR_ROM [HDR_LEN] = '{
      8'h42, 8'h4D,
      8'h36, 8'h00, 8'h03, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00,
      8'h36, 8'h00, 8'h00, 8'h00,
      8'h28, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h01, 8'h00, 8'h00,
      8'h00, 8'h01, 8'h00, 8'h00,
      8'h01, 8'h00,
      8'h18, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h03, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
      logic [7:0] b;
      b = 8'h00;
      if (idx < 6'(HDR_LEN)) b = HDR_ROM[idx];
      return b;
   endfunction
`endif

endpackage

// File: rtl/ram_frame_dumper_if.sv
// Bus bundle of the frame dumper: RAM read port plus the outgoing byte stream.
interface ram_frame_dumper_if #(
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0]                   RAM_A;
   logic                                RAM_OE;
   logic                                RAM_WE;
   logic [frame_dump_pkg::PIX_BITS-1:0] RAM_Q;

   // Stream: a byte moves when out_valid && out_ready at posedge. Once raised, out_valid
   // stays high and out_data/out_last stay stable until that transfer happens.
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   modport master (
      output RAM_A, RAM_OE, RAM_WE, out_data, out_valid, out_last,
      input  RAM_Q, out_ready
   );

   modport slave (
      input  RAM_A, RAM_OE, RAM_WE, out_data, out_valid, out_last,
      output RAM_Q, out_ready
   );
endinterface

// File: rtl/ram_frame_dumper_serializer.sv
// pixel_serializer: 2-entry pixel FIFO feeding a 3-byte MSB-first mux with a
// valid/ready output. A capture and a pop may happen in the same cycle.
module pixel_serializer
   import frame_dump_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                flush,
   input  logic                cap_valid,
   input  logic [PIX_BITS-1:0] cap_data,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [7:0]          out_data,
   output logic [1:0]          byte_sel,
   output logic                pop,
   output logic [1:0]          occ
);

   logic [PIX_BITS-1:0] mem_q [2];
   logic [PIX_BITS-1:0] mem_d [2];
   logic                wr_ptr_q, wr_ptr_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic [1:0]          occ_q, occ_d;
   logic [1:0]          byte_q, byte_d;
   logic [PIX_BITS-1:0] head;
   logic                fire;

   assign head      = mem_q[rd_ptr_q];
   assign out_valid = en && (occ_q != 2'd0);
   assign fire      = out_valid && out_ready;
   assign pop       = fire && (byte_q == 2'd2);
   assign byte_sel  = byte_q;
   assign occ       = occ_q;

   // Idle output reads as zero so the stream is quiet outside a transfer window.
   always_comb begin
      out_data = 8'h00;
      if (out_valid) begin
         case (byte_q)
            2'd0:    out_data = head[23:16];
            2'd1:    out_data = head[15:8];
            default: out_data = head[7:0];
         endcase
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      byte_d   = byte_q;
      occ_d    = occ_q + {1'b0, cap_valid} - {1'b0, pop};
      if (cap_valid) begin
         mem_d[wr_ptr_q] = cap_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (fire) begin
         if (byte_q == 2'd2) begin
            byte_d   = 2'd0;
            rd_ptr_d = ~rd_ptr_q;
         end else begin
            byte_d = byte_q + 2'd1;
         end
      end
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         occ_d    = 2'd0;
         byte_d   = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
         byte_q   <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         byte_q   <= byte_d;
      end
   end

endmodule

// File: rtl/ram_frame_dumper.sv
// ram_frame_dumper: reads a finished frame from image RAM and streams it as bytes.
// Optional feature macro DUMP_BMP_HEADER_EN prepends the 54-byte BMP header.
module ram_frame_dumper
   import frame_dump_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int PIX_W   = 24,
   parameter int NUM_PIX = 65536
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   ram_frame_dumper_if.master bus,
   output logic               busy,
   output logic               dump_done,
   output state_t             dbg_state
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_fin_q, rd_fin_d;
   logic              infl_q, infl_d;
   logic [ADDR_W-1:0] pix_idx_q, pix_idx_d;

   logic              issue;
   logic [PIX_W-1:0]  ram_word;
   logic              ser_valid, ser_pop;
   logic [7:0]        ser_data;
   logic [1:0]        ser_byte, ser_occ;
   logic              strm_valid, strm_last, strm_fire;
   logic [7:0]        strm_data;

   assign ram_word = bus.RAM_Q;

   pixel_serializer u_ser (
      .clk       (clk),
      .rst       (rst),
      .en        (state_q == PIX),
      .flush     (state_q == IDLE),
      .cap_valid (infl_q),
      .cap_data  (ram_word),
      .out_ready (bus.out_ready),
      .out_valid (ser_valid),
      .out_data  (ser_data),
      .byte_sel  (ser_byte),
      .pop       (ser_pop),
      .occ       (ser_occ)
   );

   // Buffered plus in-flight pixels never exceed the two FIFO slots.
   assign issue = (state_q == PIX) && !rd_fin_q && ((ser_occ + {1'b0, infl_q}) < 2'd2);

`ifdef DUMP_BMP_HEADER_EN
   logic [5:0] hdr_idx_q, hdr_idx_d;
   logic       hdr_valid;

   assign hdr_valid  = (state_q == HDR);
   assign strm_valid = hdr_valid || ser_valid;
   assign strm_data  = hdr_valid ? hdr_byte(hdr_idx_q) : ser_data;
`else
   assign strm_valid = ser_valid;
   assign strm_data  = ser_data;
`endif

   assign strm_last = ser_valid && (ser_byte == 2'd2) && (pix_idx_q == LAST_IDX);
   assign strm_fire = strm_valid && bus.out_ready;

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = done_q;
      rd_addr_d = rd_addr_q;
      rd_fin_d  = rd_fin_q;
      infl_d    = issue;
      pix_idx_d = pix_idx_q;
`ifdef DUMP_BMP_HEADER_EN
      hdr_idx_d = hdr_idx_q;
`endif
      if (issue) begin
         if (rd_addr_q == LAST_IDX) rd_fin_d = 1'b1;
         else                       rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
      if (ser_pop) pix_idx_d = pix_idx_q + ADDR_W'(1);

      case (state_q)
         IDLE: begin
            if (start) begin
               busy_d    = 1'b1;
               done_d    = 1'b0;
               rd_addr_d = '0;
               rd_fin_d  = 1'b0;
               pix_idx_d = '0;
`ifdef DUMP_BMP_HEADER_EN
               hdr_idx_d = '0;
               state_d   = HDR;
`else
               state_d   = PIX;
`endif
            end
         end
         HDR: begin
`ifdef DUMP_BMP_HEADER_EN
            if (strm_fire) begin
               if (hdr_idx_q == 6'(HDR_LEN - 1)) begin
                  hdr_idx_d = '0;
                  state_d   = PIX;
               end else begin
                  hdr_idx_d = hdr_idx_q + 6'd1;
               end
            end
`else
            state_d = IDLE;
`endif
         end
         PIX: begin
            if (strm_fire && strm_last) state_d = FIN;
         end
         FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_addr_q <= '0;
         rd_fin_q  <= 1'b0;
         infl_q    <= 1'b0;
         pix_idx_q <= '0;
`ifdef DUMP_BMP_HEADER_EN
         hdr_idx_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_addr_q <= rd_addr_d;
         rd_fin_q  <= rd_fin_d;
         infl_q    <= infl_d;
         pix_idx_q <= pix_idx_d;
`ifdef DUMP_BMP_HEADER_EN
         hdr_idx_q <= hdr_idx_d;
`endif
      end
   end

   assign bus.RAM_A     = rd_addr_q;
   assign bus.RAM_OE    = issue;
   assign bus.RAM_WE    = 1'b0;
   assign bus.out_data  = strm_data;
   assign bus.out_valid = strm_valid;
   assign bus.out_last  = strm_last;
   assign busy          = busy_q;
   assign dump_done     = done_q;
   assign dbg_state     = state_q;

endmodule
